// File: rtl/bit_population_counter_pkg.sv
// rtl/bit_population_counter_pkg.sv - shared mode type and tree geometry helpers for the popcount pipe
package bit_population_counter_pkg;

  typedef enum logic {
    CNT_ONES  = 1'b0,
    CNT_ZEROS = 1'b1
  } mode_e;

  function automatic int n_leaf(input int width, input int chunk);
    return (width + chunk - 1) / chunk;
  endfunction

  function automatic int latency(input int width, input int chunk);
    return 1 + $clog2(n_leaf(width, chunk));
  endfunction

  // Element width at a tree level: leaf count width plus one carry bit per level.
  function automatic int level_width(input int level, input int chunk);
    return $clog2(chunk) + 1 + level;
  endfunction

  function automatic int level_elems(input int leaves, input int level);
    return (leaves + (1 << level) - 1) >> level;
  endfunction

endpackage

// File: rtl/bit_population_counter_stage.sv
// rtl/bit_population_counter_stage.sv - one registered pairwise-sum level of the popcount adder tree
module bit_population_counter_stage
  import bit_population_counter_pkg::*;
#(
  parameter int N_IN = 2,
  parameter int W_IN = 4
) (
  input  logic                                   clk_i,
  input  logic                                   arstn_i,
  input  logic [N_IN*W_IN-1:0]                   in_data,
  input  logic                                   in_val,
  input  logic                                   next_en,
  output logic                                   en,
  output logic [((N_IN+1)/2)*(W_IN+1)-1:0]       out_data,
  output logic                                   out_val
);

  localparam int N_OUT = (N_IN + 1) / 2;
  localparam int W_OUT = W_IN + 1;

  logic [N_OUT*W_OUT-1:0] sum;

  for (genvar i = 0; i < N_OUT; i++) begin : g_pair
    if (2*i + 1 < N_IN) begin : g_add
      assign sum[i*W_OUT +: W_OUT] = W_OUT'(in_data[2*i*W_IN +: W_IN])
                                   + W_OUT'(in_data[(2*i+1)*W_IN +: W_IN]);
    end else begin : g_pass
      // Odd trailing element rides through unchanged.
      assign sum[i*W_OUT +: W_OUT] = W_OUT'(in_data[2*i*W_IN +: W_IN]);
    end
  end

  // A bubble here can always be overwritten, so this level only stalls when full and blocked.
  assign en = !out_val || next_en;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      out_val  <= 1'b0;
      out_data <= '0;
    end else if (en) begin
      out_val  <= in_val;
      out_data <= sum;
    end
  end

endmodule

// File: rtl/bit_population_counter_pipe.sv
// rtl/bit_population_counter_pipe.sv - pipelined ones/zeros population counter with bubble-collapsing backpressure
module bit_population_counter_pipe
  import bit_population_counter_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int CHUNK = 8
) (
  input  logic                   clk_i,
  input  logic                   arstn_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   mode_i,
  input  logic                   data_val_i,
  output logic                   data_ready_o,
  output logic [$clog2(WIDTH):0] data_o,
  output logic                   data_val_o,
  input  logic                   data_ready_i
);

  localparam int N_LEAF = n_leaf(WIDTH, CHUNK);
  localparam int LAT    = latency(WIDTH, CHUNK);
  localparam int PAD_W  = N_LEAF * CHUNK;
  localparam int W0     = level_width(0, CHUNK);
  localparam int OUT_W  = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0]     cond;
  logic [PAD_W-1:0]     padded;
  logic [N_LEAF*W0-1:0] leaf_cnt;

  // Invert before padding so pad bits stay zero in both modes.
  assign cond   = (mode_e'(mode_i) == CNT_ZEROS) ? ~data_i : data_i;
  assign padded = PAD_W'(cond);

  always_comb begin
    leaf_cnt = '0;
    for (int l = 0; l < N_LEAF; l++) begin
      for (int b = 0; b < CHUNK; b++) begin
        leaf_cnt[l*W0 +: W0] = leaf_cnt[l*W0 +: W0] + W0'(padded[l*CHUNK + b]);
      end
    end
  end

  for (genvar k = 0; k < LAT; k++) begin : g_lvl
    localparam int NK = level_elems(N_LEAF, k);
    localparam int WK = level_width(k, CHUNK);

    logic [NK*WK-1:0] q;
    logic             v;
    logic             en;
    logic             en_next;

    if (k == LAT - 1) begin : g_tail
      assign en_next    = data_ready_i;
      assign data_o     = q[OUT_W-1:0];
      assign data_val_o = v;
    end else begin : g_mid
      assign en_next = g_lvl[k+1].en;
    end

    if (k == 0) begin : g_leaf
      assign en           = !v || en_next;
      assign data_ready_o = en;

      always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
          v <= 1'b0;
          q <= '0;
        end else if (en) begin
          v <= data_val_i;
          q <= leaf_cnt;
        end
      end
    end else begin : g_tree
      bit_population_counter_stage #(
        .N_IN (level_elems(N_LEAF, k - 1)),
        .W_IN (level_width(k - 1, CHUNK))
      ) u_stage (
        .clk_i    (clk_i),
        .arstn_i  (arstn_i),
        .in_data  (g_lvl[k-1].q),
        .in_val   (g_lvl[k-1].v),
        .next_en  (en_next),
        .en       (en),
        .out_data (q),
        .out_val  (v)
      );
    end
  end

endmodule
